nes_pad_responder: RTL
======================

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter TURBO_FRAMES, default 4, meaning latched frames per turbo half-period (range 1-255).
REQ-002 SHALL have port clk  input  1  50 MHz system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port latch_in  input  1  host latch, asynchronous to clk, active-high.
REQ-005 SHALL have port pulse_in  input  1  host shift pulse, asynchronous to clk, shift on rising edge.
REQ-006 SHALL have port buttons  input  8  pressed=1; bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
REQ-007 SHALL have port turbo_sel  input  2  bit0 A auto-fire, bit1 B auto-fire; ignored unless the turbo feature is compiled in.
REQ-008 SHALL have port data_out  output  1  serial button data to host, active-low (0 = pressed).
REQ-009 SHALL have port frame_done  output  1  one-cycle strobe when the 8th bit has been shifted out.
REQ-010 SHALL have port extra_pulse  output  1  one-cycle strobe on any pulse edge after the 8th bit.

Function
REQ-011 SHALL pass latch_in and pulse_in through 2-flop synchronizers; edge detection on the synchronized signals; input-to-edge latency 3 clk cycles.
REQ-012 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-013 SHALL enter LOAD from any state on a synchronized latch rising edge.
REQ-014 SHALL, in LOAD, reload the 8-bit shift register from buttons (after turbo masking) every clk cycle while latch is high.
REQ-015 SHALL move LOAD -> SHIFT on a synchronized latch falling edge, clearing the 3-bit bit counter to 0.
REQ-016 SHALL drive data_out = NOT shift_reg[0] in LOAD, SHIFT and DONE; data_out = 1 in IDLE.
REQ-017 SHALL, in SHIFT on each pulse rising edge, shift the register right by one with 0 entering bit7 and increment the bit counter.
REQ-018 SHALL, on the pulse rising edge with bit counter = 7, go to DONE and assert frame_done for exactly one cycle.
REQ-019 SHALL hold data_out = 1 in DONE (register filled with zeros) and assert extra_pulse for one cycle on each pulse rising edge received there.
REQ-020 SHALL ignore pulse edges in IDLE and LOAD; no shift, no strobe.
REQ-021 SHALL give a latch rising edge priority over a simultaneous pulse rising edge: state -> LOAD, no shift, no strobe.
REQ-022 SHALL abort a partial frame on a new latch rising edge in SHIFT with no frame_done.
REQ-023 SHALL sample buttons only in LOAD; changes during SHIFT do not affect the bits being sent.

Reset
REQ-024 SHALL, while reset is low, force state IDLE, shift register 0, bit counter 0, synchronizer flops 0, turbo frame counter 0 and turbo phase 0.
REQ-025 SHALL hold data_out = 1, frame_done = 0 and extra_pulse = 0 during and immediately after reset.
REQ-026 SHALL, when reset is asserted mid-frame, discard the frame; after release the block waits in IDLE for the next latch rising edge.

Configuration
REQ-027 SHALL implement auto-fire only when macro NES_PAD_TURBO_EN is defined.
REQ-028 SHALL, with NES_PAD_TURBO_EN defined, count latch falling edges with an 8-bit counter that wraps at TURBO_FRAMES, toggle the turbo phase at each wrap, and clear buttons bit0/bit1 at load when the matching turbo_sel bit is 1 and the phase is 1.
REQ-029 SHALL, without NES_PAD_TURBO_EN, keep the turbo_sel port, ignore it, and load buttons unmodified; no turbo counter logic is synthesized.

Verification
REQ-030 SHALL cover: buttons=8'b0000_0001, latch 12 us, then 8 pulses -> data_out sequence 0,1,1,1,1,1,1,1; frame_done once after the 8th edge.
REQ-031 SHALL cover: buttons=8'b1000_0100, standard frame -> data_out 1,1,0,1,1,1,1,0; then a 9th pulse -> data_out=1 and extra_pulse once.
REQ-032 SHALL cover: latch re-raised after 3 pulses -> no frame_done; the next frame replays from bit0 with the current buttons.
REQ-033 SHALL cover: latch and pulse rising in the same cycle while in SHIFT -> state LOAD, no shift, no strobe.
REQ-034 SHALL cover: reset low after 4 pulses -> data_out=1 immediately; the next full frame is correct.
REQ-035 SHALL cover: NES_PAD_TURBO_EN defined, TURBO_FRAMES=2, turbo_sel=2'b01, A held for 8 frames -> A reads pressed,pressed,released,released,pressed,pressed,released,released.

Source files
------------

// File: rtl/nes_pad_responder.sv
// NES controller shift-register responder: synchronizes host latch/pulse, loads buttons, shifts them out active-low.
// Optional auto-fire on A/B is compiled in with `define NES_PAD_TURBO_EN.
`timescale 1ns/1ps
module nes_pad_responder #(
  parameter int TURBO_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       latch_in,
  input  logic       pulse_in,
  input  logic [7:0] buttons,
  input  logic [1:0] turbo_sel,
  output logic       data_out,
  output logic       frame_done,
  output logic       extra_pulse
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_sreg, w_sreg_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_frame_done, w_frame_done_nxt;
  logic        r_extra, w_extra_nxt;
  logic        r_latch_p0, r_latch_p1, r_latch_p2;
  logic        r_pulse_p0, r_pulse_p1, r_pulse_p2;
  logic        w_latch_rise, w_latch_fall, w_pulse_rise;
  logic [7:0]  w_btn_load;

  // Stage p0/p1: two-flop synchronizers; p2: previous value for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_latch_p0 <= 1'b0;
      r_latch_p1 <= 1'b0;
      r_latch_p2 <= 1'b0;
      r_pulse_p0 <= 1'b0;
      r_pulse_p1 <= 1'b0;
      r_pulse_p2 <= 1'b0;
    end else begin
      r_latch_p0 <= latch_in;
      r_latch_p1 <= r_latch_p0;
      r_latch_p2 <= r_latch_p1;
      r_pulse_p0 <= pulse_in;
      r_pulse_p1 <= r_pulse_p0;
      r_pulse_p2 <= r_pulse_p1;
    end
  end

  assign w_latch_rise = r_latch_p1 & ~r_latch_p2;
  assign w_latch_fall = ~r_latch_p1 & r_latch_p2;
  assign w_pulse_rise = r_pulse_p1 & ~r_pulse_p2;

`ifdef NES_PAD_TURBO_EN
  localparam logic [7:0] LP_TURBO_LAST = 8'(TURBO_FRAMES - 1);
  logic [7:0] r_turbo_cnt;
  logic       r_turbo_phase;

  // Every latch falling edge ends a frame; the phase flips every TURBO_FRAMES frames
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_turbo_cnt   <= 8'd0;
      r_turbo_phase <= 1'b0;
    end else if (w_latch_fall) begin
      if (r_turbo_cnt == LP_TURBO_LAST) begin
        r_turbo_cnt   <= 8'd0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_turbo_cnt <= r_turbo_cnt + 8'd1;
      end
    end
  end

  assign w_btn_load = {buttons[7:2],
                       buttons[1] & ~(turbo_sel[1] & r_turbo_phase),
                       buttons[0] & ~(turbo_sel[0] & r_turbo_phase)};
`else
  localparam logic [7:0] LP_TURBO_UNUSED = 8'(TURBO_FRAMES);
  logic w_unused_cfg;
  assign w_unused_cfg = ^{turbo_sel, LP_TURBO_UNUSED};
  assign w_btn_load   = buttons;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_sreg       <= 8'd0;
      r_cnt        <= 3'd0;
      r_frame_done <= 1'b0;
      r_extra      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sreg       <= w_sreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_extra      <= w_extra_nxt;
    end
  end

  // A latch rising edge wins over everything, including a coincident pulse edge
  always_comb begin
    w_state_nxt      = r_state;
    w_sreg_nxt       = r_sreg;
    w_cnt_nxt        = r_cnt;
    w_frame_done_nxt = 1'b0;
    w_extra_nxt      = 1'b0;
    if (w_latch_rise) begin
      w_state_nxt = LOAD;
      w_sreg_nxt  = w_btn_load;
    end else begin
      case (r_state)
        IDLE: ;
        LOAD: begin
          if (w_latch_fall) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = 3'd0;
          end else if (r_latch_p1) begin
            w_sreg_nxt = w_btn_load;
          end
        end
        SHIFT: begin
          if (w_pulse_rise) begin
            w_sreg_nxt = {1'b0, r_sreg[7:1]};
            w_cnt_nxt  = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_state_nxt      = DONE;
              w_frame_done_nxt = 1'b1;
            end
          end
        end
        DONE: begin
          if (w_pulse_rise) w_extra_nxt = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign data_out    = (r_state == IDLE) ? 1'b1 : ~r_sreg[0];
  assign frame_done  = r_frame_done;
  assign extra_pulse = r_extra;

endmodule
